// File: rtl/debug_term_pkg.sv
// Shared constants, state encoding and character helpers for the debug
// terminal scanner. Optional feature macro: DEBUG_TERM_CHANGE_MARK_EN.
package debug_term_pkg;

    typedef enum logic {
        ST_SNAP = 1'b0,
        ST_SCAN = 1'b1
    } term_state_e;

    // Terminal rows of the fixed CPU-state fields
    localparam int ROW_PC     = 0;
    localparam int ROW_INST   = 1;
    localparam int ROW_STATE  = 2;
    localparam int ROW_MWRITE = 3;
    localparam int ROW_MADDR  = 4;
    localparam int ROW_MRDATA = 5;
    localparam int ROW_MWDATA = 6;
    localparam int ROW_REGS   = 7;
    localparam int ROW_GRID   = 8;    // first row of the register grid

    localparam int VALUE_COL   = 8;   // value fields start here
    localparam int MARK_OFFSET = 8;   // change mark follows the 8 hex digits
    localparam int HEX_DIGITS  = 8;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    // Prompts are left-justified in 8 characters and padded with spaces,
    // so the prompt area of a row is a plain byte lookup.
    localparam logic [63:0] PROMPT_PC     = {"PC:",     {5{ASCII_SPACE}}};
    localparam logic [63:0] PROMPT_INST   = {"Inst:",   {3{ASCII_SPACE}}};
    localparam logic [63:0] PROMPT_STATE  = {"State:",  {2{ASCII_SPACE}}};
    localparam logic [63:0] PROMPT_MWRITE = {"MWrite:", ASCII_SPACE};
    localparam logic [63:0] PROMPT_MADDR  = {"MAddr:",  {2{ASCII_SPACE}}};
    localparam logic [63:0] PROMPT_MRDATA = {"MRData:", ASCII_SPACE};
    localparam logic [63:0] PROMPT_MWDATA = {"MWData:", ASCII_SPACE};
    localparam logic [63:0] PROMPT_REGS   = {"Regs:",   {3{ASCII_SPACE}}};

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (ASCII_ZERO + {4'd0, n}) : (ASCII_A + {4'd0, n} - 8'd10);
    endfunction

    function automatic logic [7:0] bin_char(input logic b);
        return b ? (ASCII_ZERO + 8'd1) : ASCII_ZERO;
    endfunction

    // Nibble k of a word, counted from the most significant nibble
    function automatic logic [3:0] nibble_of(input logic [31:0] w, input logic [2:0] k);
        logic [2:0] kk;
        kk = 3'd7 - k;
        return w[{kk, 2'b00} +: 4];
    endfunction

    // Character idx (0..7) of the prompt for one of the fixed rows 0..7
    function automatic logic [7:0] prompt_char(input logic [2:0] row, input logic [2:0] idx);
        logic [63:0] p;
        case (row)
            3'(ROW_PC):     p = PROMPT_PC;
            3'(ROW_INST):   p = PROMPT_INST;
            3'(ROW_STATE):  p = PROMPT_STATE;
            3'(ROW_MWRITE): p = PROMPT_MWRITE;
            3'(ROW_MADDR):  p = PROMPT_MADDR;
            3'(ROW_MRDATA): p = PROMPT_MRDATA;
            3'(ROW_MWDATA): p = PROMPT_MWDATA;
            3'(ROW_REGS):   p = PROMPT_REGS;
            default:        p = {8{ASCII_SPACE}};
        endcase
        return p[{3'd7 - idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/debug_term_scanner_cell.sv
// Combinational cell renderer: (row, col, snapshot) -> ASCII character.
// Holds the fixed-field decode and the register-grid decode. The change-mark
// flags arrive precomputed; they are all zero unless DEBUG_TERM_CHANGE_MARK_EN
// is defined in the top level.
module debug_term_cell
    import debug_term_pkg::*;
#(
    parameter int TERM_COLS    = 80,
    parameter int TERM_ROWS    = 30,
    parameter int NUM_REGS     = 32,
    parameter int REGS_PER_ROW = 5,
    parameter int REG_STRIDE   = 16,
    parameter int ROW_W        = $clog2(TERM_ROWS),
    parameter int COL_W        = $clog2(TERM_COLS)
) (
    input  logic [ROW_W-1:0]         row,
    input  logic [COL_W-1:0]         col,
    input  logic [31:0]              pc,
    input  logic [31:0]              inst,
    input  logic [4:0]               state,
    input  logic                     mwrite,
    input  logic [31:0]              maddr,
    input  logic [31:0]              mrdata,
    input  logic [31:0]              mwdata,
    input  logic [32*NUM_REGS-1:0]   regs,
    input  logic [NUM_REGS-1:0]      reg_changed,
    output logic [7:0]               cell_char
);

    localparam logic [ROW_W-1:0] GRID_ROW  = ROW_W'(ROW_GRID);
    localparam logic [COL_W-1:0] VCOL      = COL_W'(VALUE_COL);
    localparam logic [COL_W-1:0] HEX_LEN   = COL_W'(HEX_DIGITS);
    localparam logic [COL_W-1:0] INST_LEN  = COL_W'(32);
    localparam logic [COL_W-1:0] STATE_LEN = COL_W'(5);
    localparam logic [COL_W-1:0] MARK_OFS  = COL_W'(MARK_OFFSET);

    logic [COL_W-1:0]    field_vofs;
    logic [7:0]          field_char;
    logic [NUM_REGS-1:0] reg_hit;
    logic [7:0]          reg_char [NUM_REGS];

    // Fixed rows 0..7: prompt in columns 0..7, value digits from column 8
    always_comb begin
        field_vofs = col - VCOL;
        field_char = ASCII_SPACE;
        if (col < VCOL) begin
            field_char = prompt_char(row[2:0], col[2:0]);
        end else begin
            case (row[2:0])
                3'(ROW_PC):
                    if (field_vofs < HEX_LEN) field_char = hex_char(nibble_of(pc, field_vofs[2:0]));
                3'(ROW_INST):
                    if (field_vofs < INST_LEN) field_char = bin_char(inst[5'd31 - field_vofs[4:0]]);
                3'(ROW_STATE):
                    if (field_vofs < STATE_LEN) field_char = bin_char(state[3'd4 - field_vofs[2:0]]);
                3'(ROW_MWRITE):
                    if (field_vofs == '0) field_char = bin_char(mwrite);
                3'(ROW_MADDR):
                    if (field_vofs < HEX_LEN) field_char = hex_char(nibble_of(maddr, field_vofs[2:0]));
                3'(ROW_MRDATA):
                    if (field_vofs < HEX_LEN) field_char = hex_char(nibble_of(mrdata, field_vofs[2:0]));
                3'(ROW_MWDATA):
                    if (field_vofs < HEX_LEN) field_char = hex_char(nibble_of(mwdata, field_vofs[2:0]));
                default:
                    field_char = ASCII_SPACE;
            endcase
        end
    end

    // One decoder per register: each knows its own row and column base as
    // elaboration constants, so no runtime division is needed.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam logic [ROW_W-1:0] R_ROW = ROW_W'(ROW_GRID + gi / REGS_PER_ROW);
        localparam logic [COL_W-1:0] R_COL = COL_W'((gi % REGS_PER_ROW) * REG_STRIDE);

        logic [COL_W-1:0] ofs;
        logic [31:0]      value;

        assign value = regs[32*gi +: 32];
        // Columns left of the field wrap to a large offset (the field base
        // is at most TERM_COLS-10), so one unsigned compare covers both ends.
        assign ofs          = col - R_COL;
        assign reg_hit[gi]  = (row == R_ROW) && (ofs <= MARK_OFS);
        assign reg_char[gi] = (ofs == MARK_OFS)
                            ? (reg_changed[gi] ? ASCII_STAR : ASCII_SPACE)
                            : hex_char(nibble_of(value, ofs[2:0]));
    end

    // Final select: fixed rows above the grid, register fields inside it
    always_comb begin
        cell_char = (row < GRID_ROW) ? field_char : ASCII_SPACE;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reg_hit[r]) cell_char = reg_char[r];
        end
    end

endmodule

// File: rtl/debug_term_scanner.sv
// CPU-state terminal renderer: snapshots the CPU debug taps once per frame
// and streams every terminal cell through a ready/valid write port.
// Optional feature macro: DEBUG_TERM_CHANGE_MARK_EN (marks registers that
// changed between consecutive snapshots with '*').
module debug_term_scanner
    import debug_term_pkg::*;
#(
    parameter int TERM_COLS    = 80,
    parameter int TERM_ROWS    = 30,
    parameter int NUM_REGS     = 32,
    parameter int REGS_PER_ROW = 5,
    parameter int REG_STRIDE   = 16
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [31:0]                            cpu_pc,
    input  logic [31:0]                            cpu_instruction,
    input  logic [4:0]                             cpu_state,
    input  logic [31:0]                            cpu_mem_addr,
    input  logic [31:0]                            cpu_mem_read_data,
    input  logic [31:0]                            cpu_mem_write_data,
    input  logic                                   cpu_mem_write,
    input  logic [32*NUM_REGS-1:0]                 cpu_registers,
    input  logic                                   freeze,
    input  logic                                   terminal_ready,
    output logic                                   terminal_write,
    output logic [$clog2(TERM_ROWS*TERM_COLS)-1:0] terminal_addr,
    output logic [7:0]                             terminal_data,
    output logic                                   frame_done,
    output logic [15:0]                            frame_count
);

    localparam int ROW_W     = $clog2(TERM_ROWS);
    localparam int COL_W     = $clog2(TERM_COLS);
    localparam int ADDR_W    = $clog2(TERM_ROWS*TERM_COLS);
    localparam int GRID_ROWS = (NUM_REGS + REGS_PER_ROW - 1) / REGS_PER_ROW;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TERM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TERM_COLS - 1);

    if (ROW_GRID + GRID_ROWS > TERM_ROWS) begin : g_chk_rows
        $error("debug_term_scanner: register grid does not fit in TERM_ROWS");
    end
    if (REGS_PER_ROW * REG_STRIDE > TERM_COLS) begin : g_chk_cols
        $error("debug_term_scanner: REGS_PER_ROW*REG_STRIDE exceeds TERM_COLS");
    end
    if (TERM_COLS < 40) begin : g_chk_width
        $error("debug_term_scanner: TERM_COLS must be at least 40");
    end
    if (NUM_REGS < 1 || NUM_REGS > 32) begin : g_chk_nregs
        $error("debug_term_scanner: NUM_REGS must be in 1..32");
    end
    if (REG_STRIDE < 10) begin : g_chk_stride
        $error("debug_term_scanner: REG_STRIDE must be at least 10");
    end

    term_state_e           state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  write_q, write_d;
    logic [7:0]            data_q, data_d;
    logic                  done_q, done_d;
    logic [15:0]           count_q, count_d;

    logic [31:0]           snap_pc_q, snap_pc_d;
    logic [31:0]           snap_inst_q, snap_inst_d;
    logic [4:0]            snap_state_q, snap_state_d;
    logic                  snap_mwrite_q, snap_mwrite_d;
    logic [31:0]           snap_maddr_q, snap_maddr_d;
    logic [31:0]           snap_mrdata_q, snap_mrdata_d;
    logic [31:0]           snap_mwdata_q, snap_mwdata_d;
    logic [32*NUM_REGS-1:0] snap_regs_q, snap_regs_d;
`ifdef DEBUG_TERM_CHANGE_MARK_EN
    logic [32*NUM_REGS-1:0] prev_regs_q, prev_regs_d;
`endif

    logic                  accept;
    logic                  last_cell;
    logic [NUM_REGS-1:0]   reg_changed;
    logic [7:0]            cell_char;

    assign accept    = write_q & terminal_ready;
    assign last_cell = (row_q == ROW_LAST) && (col_q == COL_LAST);

`ifdef DEBUG_TERM_CHANGE_MARK_EN
    // Compare against the snapshot values of the frame being rendered
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_mark
        assign reg_changed[gi] = snap_regs_d[32*gi +: 32] != prev_regs_d[32*gi +: 32];
    end
`else
    assign reg_changed = '0;
`endif

    // Next state: FSM, scan position, running address, snapshot capture
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        addr_d        = addr_q;
        write_d       = write_q;
        done_d        = 1'b0;
        count_d       = count_q;
        snap_pc_d     = snap_pc_q;
        snap_inst_d   = snap_inst_q;
        snap_state_d  = snap_state_q;
        snap_mwrite_d = snap_mwrite_q;
        snap_maddr_d  = snap_maddr_q;
        snap_mrdata_d = snap_mrdata_q;
        snap_mwdata_d = snap_mwdata_q;
        snap_regs_d   = snap_regs_q;
`ifdef DEBUG_TERM_CHANGE_MARK_EN
        prev_regs_d   = prev_regs_q;
`endif
        case (state_q)
            ST_SNAP: begin
                if (!freeze) begin
                    snap_pc_d     = cpu_pc;
                    snap_inst_d   = cpu_instruction;
                    snap_state_d  = cpu_state;
                    snap_mwrite_d = cpu_mem_write;
                    snap_maddr_d  = cpu_mem_addr;
                    snap_mrdata_d = cpu_mem_read_data;
                    snap_mwdata_d = cpu_mem_write_data;
                    snap_regs_d   = cpu_registers;
`ifdef DEBUG_TERM_CHANGE_MARK_EN
                    prev_regs_d   = snap_regs_q;
`endif
                end
                row_d   = '0;
                col_d   = '0;
                addr_d  = '0;
                write_d = 1'b1;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (accept) begin
                    if (last_cell) begin
                        row_d   = '0;
                        col_d   = '0;
                        addr_d  = '0;
                        write_d = 1'b0;
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                        state_d = ST_SNAP;
                    end else begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_SNAP;
        endcase
    end

    // The output character is rendered for the position being loaded next,
    // using the snapshot as it will be after this edge.
    debug_term_cell #(
        .TERM_COLS    (TERM_COLS),
        .TERM_ROWS    (TERM_ROWS),
        .NUM_REGS     (NUM_REGS),
        .REGS_PER_ROW (REGS_PER_ROW),
        .REG_STRIDE   (REG_STRIDE),
        .ROW_W        (ROW_W),
        .COL_W        (COL_W)
    ) u_cell (
        .row         (row_d),
        .col         (col_d),
        .pc          (snap_pc_d),
        .inst        (snap_inst_d),
        .state       (snap_state_d),
        .mwrite      (snap_mwrite_d),
        .maddr       (snap_maddr_d),
        .mrdata      (snap_mrdata_d),
        .mwdata      (snap_mwdata_d),
        .regs        (snap_regs_d),
        .reg_changed (reg_changed),
        .cell_char   (cell_char)
    );

    // Output data: load a new character on frame start or on each accept
    always_comb begin
        data_d = data_q;
        if (state_q == ST_SNAP) begin
            data_d = cell_char;
        end else if (accept) begin
            data_d = last_cell ? ASCII_SPACE : cell_char;
        end
    end

    // All state: FSM, counters, snapshot and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_SNAP;
            row_q         <= '0;
            col_q         <= '0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            data_q        <= ASCII_SPACE;
            done_q        <= 1'b0;
            count_q       <= '0;
            snap_pc_q     <= '0;
            snap_inst_q   <= '0;
            snap_state_q  <= '0;
            snap_mwrite_q <= 1'b0;
            snap_maddr_q  <= '0;
            snap_mrdata_q <= '0;
            snap_mwdata_q <= '0;
            snap_regs_q   <= '0;
`ifdef DEBUG_TERM_CHANGE_MARK_EN
            prev_regs_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            data_q        <= data_d;
            done_q        <= done_d;
            count_q       <= count_d;
            snap_pc_q     <= snap_pc_d;
            snap_inst_q   <= snap_inst_d;
            snap_state_q  <= snap_state_d;
            snap_mwrite_q <= snap_mwrite_d;
            snap_maddr_q  <= snap_maddr_d;
            snap_mrdata_q <= snap_mrdata_d;
            snap_mwdata_q <= snap_mwdata_d;
            snap_regs_q   <= snap_regs_d;
`ifdef DEBUG_TERM_CHANGE_MARK_EN
            prev_regs_q   <= prev_regs_d;
`endif
        end
    end

    assign terminal_write = write_q;
    assign terminal_addr  = addr_q;
    assign terminal_data  = data_q;
    assign frame_done     = done_q;
    assign frame_count    = count_q;

endmodule
